// File: rtl/hdmi_video_timing_gen_if.sv
// Video timing bundle from the raster generator to the pixel source and HDMI transmitter.
interface hdmi_video_timing_gen_if #(
    parameter int XW = 12,
    parameter int YW = 11
);
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_start;
    logic          frame_start;
    logic          running;

    modport master (
        output hsync, vsync, de, x, y, line_start, frame_start, running
    );

    modport slave (
        input hsync, vsync, de, x, y, line_start, frame_start, running
    );
endinterface

// File: rtl/hdmi_video_timing_gen.sv
// Raster timing generator in the pixel-clock domain; waits for a stable PLL lock,
// then produces sync, data enable, coordinates and line/frame strobes.
module hdmi_video_timing_gen #(
    parameter int H_ACTIVE      = 1920,
    parameter int H_FP          = 88,
    parameter int H_SYNC        = 44,
    parameter int H_BP          = 148,
    parameter int V_ACTIVE      = 1080,
    parameter int V_FP          = 4,
    parameter int V_SYNC        = 5,
    parameter int V_BP          = 36,
    parameter bit HS_POL        = 1'b1,
    parameter bit VS_POL        = 1'b1,
    parameter int SETTLE_CYCLES = 1024,
    parameter int XW            = 12,
    parameter int YW            = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pll_locked,
    hdmi_video_timing_gen_if.master  vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SW      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT_END  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] H_SYNC_BEG = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] H_SYNC_END = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT_END  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] V_SYNC_BEG = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] V_SYNC_END = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [XW-1:0] h_q, h_d;
    logic [YW-1:0] v_q, v_d;

    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          running_q, running_d;

    logic          active;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        h_d      = h_q;
        v_d      = v_q;
        case (state_q)
            WAIT_LOCK: begin
                settle_d = '0;
                h_d      = '0;
                v_d      = '0;
                if (pll_locked) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!pll_locked) begin
                    state_d  = WAIT_LOCK;
                    settle_d = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d  = RUN;
                    settle_d = '0;
                    h_d      = '0;
                    v_d      = '0;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            RUN: begin
                if (!pll_locked) begin
                    state_d = WAIT_LOCK;
                    h_d     = '0;
                    v_d     = '0;
                end else if (h_q == H_LAST) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? '0 : v_q + YW'(1);
                end else begin
                    h_d = h_q + XW'(1);
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    // Outputs trail the counters by one cycle and go idle on the same edge that loses lock.
    always_comb begin
        active        = (state_q == RUN) && pll_locked;
        de_d          = active && (h_q < H_ACT_END) && (v_q < V_ACT_END);
        x_d           = de_d ? h_q : '0;
        y_d           = de_d ? v_q : '0;
        hsync_d       = (active && (h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END)) ? HS_POL : ~HS_POL;
        vsync_d       = (active && (v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END)) ? VS_POL : ~VS_POL;
        line_start_d  = active && (h_q == '0);
        frame_start_d = line_start_d && (v_q == '0);
        running_d     = active;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_LOCK;
            settle_q      <= '0;
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            running_q     <= running_d;
        end
    end

    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.de          = de_q;
    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;
    assign vid.running     = running_q;
endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// Directed bench for hdmi_video_timing_gen using a 16x8 raster and a 4-cycle settle.
module tb_hdmi_video_timing_gen;
    localparam int H_TOTAL = 16;
    localparam int V_TOTAL = 8;
    localparam int F_TOTAL = H_TOTAL * V_TOTAL;

    logic clk = 1'b0;
    logic rst;
    logic pll_locked;

    int compared   = 0;
    int mismatched = 0;
    int vs_high    = 0;
    int de_high    = 0;
    int ls_count   = 0;

    hdmi_video_timing_gen_if #(.XW(12), .YW(11)) vid ();

    hdmi_video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1),
        .SETTLE_CYCLES(4), .XW(12), .YW(11)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .vid        (vid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic l);
        rst        = r;
        pll_locked = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " hsync"}, int'(vid.hsync), 0);
        checkOutput({tag, " vsync"}, int'(vid.vsync), 0);
        checkOutput({tag, " de"}, int'(vid.de), 0);
        checkOutput({tag, " x"}, int'(vid.x), 0);
        checkOutput({tag, " y"}, int'(vid.y), 0);
        checkOutput({tag, " line_start"}, int'(vid.line_start), 0);
        checkOutput({tag, " frame_start"}, int'(vid.frame_start), 0);
        checkOutput({tag, " running"}, int'(vid.running), 0);
    endtask

    task automatic idleTicks(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            checkIdle($sformatf("%s e%0d", tag, i + 1));
        end
    endtask

    // k counts output cycles since a frame start; the expected raster is derived from it directly.
    task automatic checkRaster(input int k);
        int kk, h, v, exp_de;
        string t;
        kk     = k % F_TOTAL;
        h      = kk % H_TOTAL;
        v      = kk / H_TOTAL;
        exp_de = (h < 8 && v < 4) ? 1 : 0;
        t      = $sformatf("k=%0d", k);
        checkOutput({t, " running"}, int'(vid.running), 1);
        checkOutput({t, " de"}, int'(vid.de), exp_de);
        checkOutput({t, " x"}, int'(vid.x), exp_de ? h : 0);
        checkOutput({t, " y"}, int'(vid.y), exp_de ? v : 0);
        checkOutput({t, " hsync"}, int'(vid.hsync), (h >= 10 && h < 13) ? 1 : 0);
        checkOutput({t, " vsync"}, int'(vid.vsync), (v >= 5 && v < 7) ? 1 : 0);
        checkOutput({t, " line_start"}, int'(vid.line_start), (h == 0) ? 1 : 0);
        checkOutput({t, " frame_start"}, int'(vid.frame_start), (kk == 0) ? 1 : 0);
        if (k < F_TOTAL) begin
            if (vid.vsync === 1'b1) vs_high++;
            if (vid.de === 1'b1) de_high++;
            if (vid.line_start === 1'b1) ls_count++;
        end
    endtask

    task automatic runRaster(input int start_k, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            checkRaster(start_k + i);
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0);
        repeat (3) tick();
        checkIdle("reset");

        // Bring-up: five idle edges, then the first frame begins on edge 6.
        applyStimulus(1'b0, 1'b1);
        idleTicks(5, "bringup");
        vs_high  = 0;
        de_high  = 0;
        ls_count = 0;
        runRaster(0, F_TOTAL + 1);
        checkOutput("frame vsync cycles", vs_high, 32);
        checkOutput("frame de cycles", de_high, 32);
        checkOutput("frame line_starts", ls_count, 8);

        // Advance until the counter holds h=5,v=2, then drop lock.
        runRaster(F_TOTAL + 1, 36);
        applyStimulus(1'b0, 1'b0);
        tick();
        checkIdle("lockloss");

        applyStimulus(1'b0, 1'b1);
        idleTicks(5, "relock");
        runRaster(0, 20);

        applyStimulus(1'b0, 1'b0);
        tick();
        checkIdle("lockloss2");

        // Lock glitch after three locked cycles restarts the settle count.
        applyStimulus(1'b0, 1'b1);
        idleTicks(3, "glitch_pre");
        applyStimulus(1'b0, 1'b0);
        idleTicks(1, "glitch_drop");
        applyStimulus(1'b0, 1'b1);
        idleTicks(5, "glitch_post");
        runRaster(0, 96);

        // Counter now holds v=6; reset with lock still held.
        applyStimulus(1'b1, 1'b1);
        tick();
        checkIdle("midreset");
        idleTicks(2, "midreset_hold");
        applyStimulus(1'b0, 1'b1);
        idleTicks(5, "rebring");
        runRaster(0, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end
endmodule
